// File: rtl/id_branch_ctrl_pkg.sv
// Shared opcodes, instruction field positions and FSM state type for the ID-stage
// branch controller and its comparator.
package id_pkg;

    localparam logic [5:0]  OPC_BEQ   = 6'h04;
    localparam logic [5:0]  OPC_BNE   = 6'h05;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/id_branch_ctrl_if.sv
// Bundle between the fetch stage / register file and the ID branch controller.
// slave = the controller, master = whatever drives fetch outputs and operands.
interface id_branch_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      PC;
    logic [31:0]      instruction;
    logic             hazard_stall;
    logic [31:0]      rs_data;
    logic [31:0]      rt_data;
    logic [4:0]       rs_addr;
    logic [4:0]       rt_addr;
    logic             if_en;
    logic             Br_taken;
    logic [15:0]      Br_offset;
    logic             id_valid;
    logic [31:0]      id_pc;
    logic [31:0]      id_instr;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic             stall_err;

    modport master (
        output PC, instruction, hazard_stall, rs_data, rt_data,
        input  rs_addr, rt_addr, if_en, Br_taken, Br_offset,
        input  id_valid, id_pc, id_instr, br_cnt, taken_cnt, stall_err
    );

    modport slave (
        input  PC, instruction, hazard_stall, rs_data, rt_data,
        output rs_addr, rt_addr, if_en, Br_taken, Br_offset,
        output id_valid, id_pc, id_instr, br_cnt, taken_cnt, stall_err
    );

endinterface

// File: rtl/id_branch_ctrl_br_compare.sv
// BEQ/BNE decode and operand comparison; purely combinational so any later
// resolution point can reuse it.
module br_compare
    import id_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        is_br,
    output logic        cond
);

    always_comb begin
        is_br = (opcode == OPC_BEQ) || (opcode == OPC_BNE);
        cond  = (opcode == OPC_BEQ) ? (rs_data == rt_data) : (rs_data != rt_data);
    end

endmodule

// File: rtl/id_branch_ctrl.sv
// IF/ID register owner: resolves BEQ/BNE in ID, squashes wrong-path fetches,
// freezes fetch on hazards and keeps branch statistics. Build option: BR_DELAY_SLOT_EN.
module id_branch_ctrl
    import id_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int STALL_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    id_branch_ctrl_if.slave  bus
);

    localparam int                SCNT_W    = $clog2(STALL_MAX + 1);
    localparam logic [SCNT_W-1:0] STALL_LIM = SCNT_W'(STALL_MAX);

    state_e            state;
    logic              valid;
    logic [31:0]       pc_q;
    logic [31:0]       instr_q;
    logic [SCNT_W-1:0] stall_cnt;
    logic              err_q;
    logic [CNT_W-1:0]  br_q;
    logic [CNT_W-1:0]  taken_q;

    logic [5:0]        opcode;
    logic              op_br;
    logic              op_cond;
    logic              active;
    logic              stall;
    logic              is_br;
    logic              take;

    assign opcode = instr_q[OPC_MSB:OPC_LSB];

    br_compare u_br_compare (
        .opcode  (opcode),
        .rs_data (bus.rs_data),
        .rt_data (bus.rt_data),
        .is_br   (op_br),
        .cond    (op_cond)
    );

    // NOTE: every output of this block is fully assigned on every path, so no latch is inferred.
    always_comb begin
        active = (state != FLUSH);
        // A hazard only matters for a live instruction; an empty or squashed slot never stalls.
        stall  = active && valid && bus.hazard_stall;
        is_br  = active && valid && op_br;
        take   = is_br && !stall && op_cond;
    end

    assign bus.rs_addr   = instr_q[RS_MSB:RS_LSB];
    assign bus.rt_addr   = instr_q[RT_MSB:RT_LSB];
    assign bus.if_en     = !stall;
    assign bus.Br_taken  = take;
    assign bus.Br_offset = instr_q[IMM_MSB:IMM_LSB];
    assign bus.id_valid  = active && valid && !stall;
    assign bus.id_pc     = pc_q;
    assign bus.id_instr  = instr_q;
    assign bus.br_cnt    = br_q;
    assign bus.taken_cnt = taken_q;
    assign bus.stall_err = err_q;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            valid     <= 1'b0;
            pc_q      <= '0;
            instr_q   <= NOP_INSTR;
            stall_cnt <= '0;
            err_q     <= 1'b0;
            br_q      <= '0;
            taken_q   <= '0;
        end else if (stall) begin
            state <= STALL;
            if (stall_cnt != STALL_LIM) stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt >= STALL_LIM - 1'b1) err_q <= 1'b1;
        end else begin
            stall_cnt <= '0;
            pc_q      <= bus.PC;
            instr_q   <= bus.instruction;
            if (is_br && (br_q != '1))   br_q    <= br_q + 1'b1;
            if (take && (taken_q != '1)) taken_q <= taken_q + 1'b1;
`ifdef BR_DELAY_SLOT_EN
            valid <= 1'b1;
            state <= RUN;
`else
            // The word fetched alongside a taken branch is wrong-path and dies here.
            valid <= !take;
            if (take) state <= FLUSH;
            else      state <= RUN;
`endif
        end
    end

endmodule

// File: tb/tb_id_branch_ctrl.sv
// Self-checking bench for id_branch_ctrl: directed scenarios plus a randomized run
// against a pipeline-level reference model.
`timescale 1ns/1ps
module tb_id_branch_ctrl;

    localparam int CNT_W     = 5;
    localparam int STALL_MAX = 15;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
`ifdef BR_DELAY_SLOT_EN
    localparam bit DELAY_SLOT = 1'b1;
`else
    localparam bit DELAY_SLOT = 1'b0;
`endif

    localparam logic [31:0] I_BEQ = 32'h1022_0003;  // beq r1,r2,+3
    localparam logic [31:0] I_BNE = 32'h1422_0007;  // bne r1,r2,+7
    localparam logic [31:0] I_ADD = 32'h0022_1820;  // add r3,r1,r2

    logic clk = 1'b0;
    logic rst = 1'b0;

    id_branch_ctrl_if #(.CNT_W(CNT_W)) bus ();

    id_branch_ctrl #(.CNT_W(CNT_W), .STALL_MAX(STALL_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: what currently sits in ID and the running statistics.
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    int          m_run;
    logic        m_err;
    int          m_br;
    int          m_taken;
    logic        e_hold;
    logic        e_br;
    logic        e_take;

    task automatic model_reset();
        m_valid = 1'b0; m_pc = '0; m_instr = '0;
        m_run = 0; m_err = 1'b0; m_br = 0; m_taken = 0;
    endtask

    task automatic model_eval();
        logic [5:0] op;
        op     = m_instr[31:26];
        e_br   = m_valid && (op == 6'h04 || op == 6'h05);
        e_hold = m_valid && bus.hazard_stall;
        e_take = e_br && !e_hold &&
                 ((op == 6'h04) ? (bus.rs_data == bus.rt_data) : (bus.rs_data != bus.rt_data));
    endtask

    task automatic model_edge();
        model_eval();
        if (e_hold) begin
            if (m_run < STALL_MAX) m_run++;
            if (m_run >= STALL_MAX) m_err = 1'b1;
        end else begin
            m_run = 0;
            if (e_br && m_br < CNT_MAX) m_br++;
            if (e_take && m_taken < CNT_MAX) m_taken++;
            m_pc    = bus.PC;
            m_instr = bus.instruction;
            m_valid = DELAY_SLOT || !e_take;
        end
    endtask

    task automatic step(input logic [31:0] pc, input logic [31:0] instr, input logic hz,
                        input logic [31:0] rs, input logic [31:0] rt);
        bus.PC = pc; bus.instruction = instr; bus.hazard_stall = hz;
        bus.rs_data = rs; bus.rt_data = rt;
        #1;
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        #1;
        model_reset();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        vectors++; if ({bus.if_en, bus.Br_taken, bus.id_valid, bus.stall_err} !== 4'b1000) begin miscompares++; $display("FAIL reset_flags: got %b expected 1000", {bus.if_en, bus.Br_taken, bus.id_valid, bus.stall_err}); end
        vectors++; if ({bus.id_pc, bus.id_instr, bus.Br_offset} !== 80'h0) begin miscompares++; $display("FAIL reset_regs: got pc=%h instr=%h off=%h expected zeros", bus.id_pc, bus.id_instr, bus.Br_offset); end
        vectors++; if ({bus.br_cnt, bus.taken_cnt} !== '0) begin miscompares++; $display("FAIL reset_cnt: got br=%0d taken=%0d expected 0", bus.br_cnt, bus.taken_cnt); end
        release_reset();
        step(32'h40, I_ADD, 1'b0, 32'h0, 32'h0); advance();
        step(32'h44, I_ADD, 1'b1, 32'h0, 32'h0);
        vectors++; if ({bus.if_en, bus.id_valid} !== 2'b00) begin miscompares++; $display("FAIL reset_stall_entry: got %b expected 00", {bus.if_en, bus.id_valid}); end
        advance();
        step(32'h48, I_ADD, 1'b1, 32'h0, 32'h0); advance();
        step(32'h4c, I_ADD, 1'b1, 32'h0, 32'h0);
        assert_reset();
        vectors++; if ({bus.if_en, bus.Br_taken, bus.id_valid, bus.stall_err} !== 4'b1000) begin miscompares++; $display("FAIL reset_mid_stall: got %b expected 1000", {bus.if_en, bus.Br_taken, bus.id_valid, bus.stall_err}); end
        vectors++; if (bus.id_instr !== 32'h0) begin miscompares++; $display("FAIL reset_mid_stall_instr: got %h expected 0", bus.id_instr); end
        release_reset();
        step(32'h80, I_ADD, 1'b1, 32'h0, 32'h0);
        vectors++; if ({bus.if_en, bus.id_valid} !== 2'b10) begin miscompares++; $display("FAIL hazard_when_empty: got %b expected 10", {bus.if_en, bus.id_valid}); end
        advance();
        step(32'h84, I_ADD, 1'b0, 32'h0, 32'h0);
        vectors++; if ({bus.id_valid, bus.id_pc} !== {1'b1, 32'h80}) begin miscompares++; $display("FAIL reset_first_load: got v=%b pc=%h expected v=1 pc=80", bus.id_valid, bus.id_pc); end
        advance();
    endtask

    task automatic test_beq_taken();
        assert_reset(); release_reset();
        step(32'h100, I_BEQ, 1'b0, 32'h5, 32'h5); advance();
        step(32'h104, I_ADD, 1'b0, 32'h5, 32'h5);
        vectors++; if ({bus.if_en, bus.Br_taken, bus.id_valid} !== 3'b111) begin miscompares++; $display("FAIL beq_resolve: got %b expected 111", {bus.if_en, bus.Br_taken, bus.id_valid}); end
        vectors++; if ({bus.Br_offset, bus.rs_addr, bus.rt_addr} !== {16'h0003, 5'd1, 5'd2}) begin miscompares++; $display("FAIL beq_fields: got off=%h rs=%0d rt=%0d expected 0003/1/2", bus.Br_offset, bus.rs_addr, bus.rt_addr); end
        advance();
        step(32'h110, I_ADD, 1'b0, 32'h5, 32'h5);
        vectors++; if ({bus.id_valid, bus.Br_taken, bus.if_en} !== {DELAY_SLOT, 2'b01}) begin miscompares++; $display("FAIL beq_squash: got %b expected %b", {bus.id_valid, bus.Br_taken, bus.if_en}, {DELAY_SLOT, 2'b01}); end
        vectors++; if ({bus.br_cnt, bus.taken_cnt} !== {5'd1, 5'd1}) begin miscompares++; $display("FAIL beq_counts: got br=%0d taken=%0d expected 1/1", bus.br_cnt, bus.taken_cnt); end
        advance();
        step(32'h114, I_ADD, 1'b0, 32'h5, 32'h5);
        vectors++; if ({bus.id_valid, bus.id_pc} !== {1'b1, 32'h110}) begin miscompares++; $display("FAIL beq_target: got v=%b pc=%h expected v=1 pc=110", bus.id_valid, bus.id_pc); end
        advance();
    endtask

    task automatic test_bne_not_taken();
        assert_reset(); release_reset();
        step(32'h200, I_BNE, 1'b0, 32'hA, 32'hA); advance();
        step(32'h204, I_ADD, 1'b0, 32'hA, 32'hA);
        vectors++; if ({bus.Br_taken, bus.id_valid, bus.Br_offset} !== {2'b01, 16'h0007}) begin miscompares++; $display("FAIL bne_resolve: got t=%b v=%b off=%h expected 0/1/0007", bus.Br_taken, bus.id_valid, bus.Br_offset); end
        advance();
        step(32'h208, I_ADD, 1'b0, 32'hA, 32'hA);
        vectors++; if ({bus.id_valid, bus.id_pc, bus.br_cnt, bus.taken_cnt} !== {1'b1, 32'h204, 5'd1, 5'd0}) begin miscompares++; $display("FAIL bne_after: got v=%b pc=%h br=%0d taken=%0d expected 1/204/1/0", bus.id_valid, bus.id_pc, bus.br_cnt, bus.taken_cnt); end
        advance();
    endtask

    task automatic test_stall_then_taken();
        assert_reset(); release_reset();
        step(32'h300, I_BEQ, 1'b0, 32'h5, 32'h5); advance();
        for (int c = 0; c < 2; c++) begin
            step(32'h304, I_ADD, 1'b1, 32'h5, 32'h5);
            vectors++; if ({bus.if_en, bus.id_valid, bus.Br_taken} !== 3'b000) begin miscompares++; $display("FAIL stall_cycle%0d: got %b expected 000", c, {bus.if_en, bus.id_valid, bus.Br_taken}); end
            vectors++; if ({bus.id_instr, bus.id_pc, bus.br_cnt} !== {I_BEQ, 32'h300, 5'd0}) begin miscompares++; $display("FAIL stall_hold%0d: got instr=%h pc=%h br=%0d", c, bus.id_instr, bus.id_pc, bus.br_cnt); end
            advance();
        end
        step(32'h304, I_ADD, 1'b0, 32'h5, 32'h5);
        vectors++; if ({bus.if_en, bus.id_valid, bus.Br_taken} !== 3'b111) begin miscompares++; $display("FAIL stall_release: got %b expected 111", {bus.if_en, bus.id_valid, bus.Br_taken}); end
        advance();
        step(32'h310, I_ADD, 1'b0, 32'h5, 32'h5);
        vectors++; if ({bus.id_valid, bus.br_cnt, bus.taken_cnt} !== {DELAY_SLOT, 5'd1, 5'd1}) begin miscompares++; $display("FAIL stall_after: got v=%b br=%0d taken=%0d", bus.id_valid, bus.br_cnt, bus.taken_cnt); end
        advance();
    endtask

    task automatic test_stall_watchdog();
        assert_reset(); release_reset();
        step(32'h500, I_ADD, 1'b0, 32'h0, 32'h0); advance();
        for (int k = 0; k <= 16; k++) begin
            step(32'h504, I_BEQ, 1'b1, 32'h0, 32'h0);
            vectors++; if ({bus.stall_err, bus.if_en} !== {(k >= STALL_MAX), 1'b0}) begin miscompares++; $display("FAIL watchdog_k%0d: got err=%b if_en=%b expected err=%b if_en=0", k, bus.stall_err, bus.if_en, (k >= STALL_MAX)); end
            advance();
        end
        step(32'h504, I_ADD, 1'b0, 32'h0, 32'h0);
        vectors++; if ({bus.stall_err, bus.id_valid, bus.if_en, bus.id_pc} !== {3'b111, 32'h500}) begin miscompares++; $display("FAIL watchdog_release: got err=%b v=%b en=%b pc=%h", bus.stall_err, bus.id_valid, bus.if_en, bus.id_pc); end
        advance();
        step(32'h508, I_ADD, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.stall_err !== 1'b1) begin miscompares++; $display("FAIL watchdog_sticky: got %b expected 1", bus.stall_err); end
        assert_reset();
        vectors++; if (bus.stall_err !== 1'b0) begin miscompares++; $display("FAIL watchdog_clear: got %b expected 0", bus.stall_err); end
        release_reset();
    endtask

    task automatic test_reset_in_flush();
        assert_reset(); release_reset();
        step(32'h600, I_BEQ, 1'b0, 32'h5, 32'h5); advance();
        step(32'h604, I_ADD, 1'b0, 32'h5, 32'h5); advance();
        step(32'h700, I_ADD, 1'b0, 32'h5, 32'h5);
        assert_reset();
        vectors++; if ({bus.id_valid, bus.Br_taken, bus.if_en, bus.Br_offset} !== {3'b001, 16'h0}) begin miscompares++; $display("FAIL flush_reset_flags: got v=%b t=%b en=%b off=%h", bus.id_valid, bus.Br_taken, bus.if_en, bus.Br_offset); end
        vectors++; if ({bus.br_cnt, bus.taken_cnt} !== '0) begin miscompares++; $display("FAIL flush_reset_cnt: got br=%0d taken=%0d expected 0", bus.br_cnt, bus.taken_cnt); end
        release_reset();
        step(32'h710, I_BEQ, 1'b0, 32'h1, 32'h1); advance();
        step(32'h714, I_ADD, 1'b0, 32'h1, 32'h1);
        vectors++; if ({bus.id_valid, bus.Br_taken, bus.id_pc} !== {2'b11, 32'h710}) begin miscompares++; $display("FAIL flush_reset_run: got v=%b t=%b pc=%h", bus.id_valid, bus.Br_taken, bus.id_pc); end
        advance();
    endtask

    task automatic test_back_to_back();
        assert_reset(); release_reset();
        step(32'h800, I_BEQ, 1'b0, 32'h5, 32'h5); advance();
        step(32'h804, I_BNE, 1'b0, 32'h5, 32'h5); advance();
        step(32'h900, I_ADD, 1'b0, 32'h1, 32'h2);
        vectors++; if ({bus.Br_taken, bus.br_cnt} !== {DELAY_SLOT, 5'd1}) begin miscompares++; $display("FAIL b2b_successor: got t=%b br=%0d expected t=%b br=1", bus.Br_taken, bus.br_cnt, DELAY_SLOT); end
        advance();
        step(32'h904, I_ADD, 1'b0, 32'h1, 32'h2);
        vectors++; if ({bus.br_cnt, bus.taken_cnt} !== {5'(1 + DELAY_SLOT), 5'(1 + DELAY_SLOT)}) begin miscompares++; $display("FAIL b2b_counts: got br=%0d taken=%0d", bus.br_cnt, bus.taken_cnt); end
        advance();
    endtask

    task automatic test_random();
        logic [31:0] pc, instr, rs, rt;
        int          hz_left;
        logic        hz;
        assert_reset(); release_reset();
        pc = 32'h1000; hz_left = 0;
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 3))
                0:       instr = {6'h04, 26'($urandom)};
                1:       instr = {6'h05, 26'($urandom)};
                2:       instr = {6'h00, 26'($urandom)};
                default: instr = $urandom;
            endcase
            rs = 32'($urandom_range(0, 3));
            rt = $urandom_range(0, 1) ? rs : 32'($urandom_range(0, 3));
            if (hz_left == 0 && $urandom_range(0, 39) == 0) hz_left = $urandom_range(1, 20);
            hz = (hz_left > 0) || ($urandom_range(0, 5) == 0);
            if (hz_left > 0) hz_left--;
            step(pc, instr, hz, rs, rt);
            model_eval();
            vectors++; if ({bus.if_en, bus.Br_taken, bus.id_valid} !== {!e_hold, e_take, m_valid && !e_hold}) begin miscompares++; $display("FAIL rand_flags@%0d: got %b expected %b", i, {bus.if_en, bus.Br_taken, bus.id_valid}, {!e_hold, e_take, m_valid && !e_hold}); end
            vectors++; if ({bus.id_pc, bus.id_instr} !== {m_pc, m_instr}) begin miscompares++; $display("FAIL rand_ifid@%0d: got %h/%h expected %h/%h", i, bus.id_pc, bus.id_instr, m_pc, m_instr); end
            vectors++; if ({bus.Br_offset, bus.rs_addr, bus.rt_addr} !== {m_instr[15:0], m_instr[25:21], m_instr[20:16]}) begin miscompares++; $display("FAIL rand_fields@%0d: got %h expected %h", i, {bus.Br_offset, bus.rs_addr, bus.rt_addr}, {m_instr[15:0], m_instr[25:21], m_instr[20:16]}); end
            vectors++; if ({bus.br_cnt, bus.taken_cnt, bus.stall_err} !== {CNT_W'(m_br), CNT_W'(m_taken), m_err}) begin miscompares++; $display("FAIL rand_stats@%0d: got br=%0d taken=%0d err=%b expected %0d/%0d/%b", i, bus.br_cnt, bus.taken_cnt, bus.stall_err, m_br, m_taken, m_err); end
            if (!hz) pc = pc + 32'd4;
            advance();
        end
    endtask

    initial begin
        bus.PC = '0; bus.instruction = '0; bus.hazard_stall = 1'b0;
        bus.rs_data = '0; bus.rt_data = '0;
        model_reset();
        @(negedge clk);
        #1;
        test_reset();
        test_beq_taken();
        test_bne_not_taken();
        test_stall_then_taken();
        test_stall_watchdog();
        test_reset_in_flush();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_branch_ctrl.md
Name: id_branch_ctrl

Overview:
- ID-side partner of the fetch stage: owns the IF/ID pipeline register, fed by the fetch stage's PC and instruction outputs.
- Resolves BEQ/BNE in ID and drives the fetch stage's Br_taken, Br_offset and en inputs.
- Handles wrong-path squash (flush) and hazard stalls, and keeps saturating branch statistics counters.

Parameters:
- CNT_W, 16, width of the branch/taken statistics counters.
- STALL_MAX, 15, consecutive stall cycles tolerated before stall_err is raised.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- PC  in  32  fetch-stage PC (address of instruction).
- instruction  in  32  fetch-stage instruction word.
- hazard_stall  in  1  operands of the ID instruction are not yet available.
- rs_data  in  32  register file read data for rs.
- rt_data  in  32  register file read data for rt.
- rs_addr  out  5  id_instr[25:21].
- rt_addr  out  5  id_instr[20:16].
- if_en  out  1  drives the fetch-stage en; 0 freezes PC.
- Br_taken  out  1  to fetch stage: take branch this cycle.
- Br_offset  out  16  to fetch stage: id_instr[15:0], unmodified.
- id_valid  out  1  ID instruction is valid and not stalled.
- id_pc  out  32  registered PC.
- id_instr  out  32  registered instruction.
- br_cnt  out  CNT_W  branches resolved.
- taken_cnt  out  CNT_W  branches taken.
- stall_err  out  1  sticky watchdog flag.

Behaviour:
- Reset values (rst=0, asynchronous): state RUN, IF/ID valid 0, id_pc 0, id_instr 0 (NOP), counters 0, stall counter 0, stall_err 0. Combinational outputs at reset: if_en 1, Br_taken 0, Br_offset 0.
- is_br = IF/ID valid and opcode (id_instr[31:26]) is OPC_BEQ (6'h04) or OPC_BNE (6'h05).
- cond = (rs_data==rt_data) for BEQ, (rs_data!=rt_data) for BNE.
- Target arithmetic (the -1 correction and <<2) belongs to the fetch stage; this block never adjusts the offset.
- States:
  - RUN:
    - hazard_stall=1: if_en=0, IF/ID holds, id_valid=0, Br_taken=0, go to STALL.
    - Otherwise: if_en=1, id_valid=valid, Br_taken=is_br&cond (combinational, same cycle).
    - At the edge, IF/ID loads PC/instruction with valid=1.
    - If Br_taken, the loaded word is wrong-path: valid<=0, go to FLUSH.
  - STALL:
    - if_en=0, Br_taken=0, id_valid=0; the stall counter increments, saturating at STALL_MAX.
    - When it reaches STALL_MAX, stall_err<=1 (sticky until reset).
    - hazard_stall=0: return to RUN and re-evaluate the held instruction that same cycle; the counter clears.
  - FLUSH:
    - One cycle; id_valid=0, Br_taken=0, if_en=1; IF/ID loads the target instruction with valid=1; go to RUN.
    - hazard_stall is ignored while IF/ID is invalid.
- Simultaneous events:
  - hazard_stall and a taken condition: stall wins; no branch is issued until operands are ready.
  - A branch in ID whose successor is also a branch: the successor is flushed and is not counted.
- Counters: br_cnt += 1 per RUN cycle with is_br & !hazard_stall; taken_cnt += 1 when Br_taken. Both saturate at all-ones.
- Reset mid-STALL or mid-FLUSH returns to RUN with IF/ID invalid.

Optional Feature:
- Macro: BR_DELAY_SLOT_EN.
- Defined: the instruction fetched during the branch's ID cycle is a delay slot. It is loaded with valid=1 and executes; the FLUSH state is bypassed (RUN->RUN).
- Undefined: the wrong-path squash described in Behaviour.
- Counters are unaffected either way.

Decomposition:
- Package id_pkg holds:
  - OPC_BEQ, OPC_BNE, NOP_INSTR;
  - state enum {RUN, STALL, FLUSH};
  - opcode/field slice constants.
- Sub-module: br_compare (opcode + rs_data/rt_data -> is_br, cond), combinational, reused by any later resolution point.

Test Plan:
- BEQ r1,r2,16'h0003 with rs_data=rt_data=32'h5 -> Br_taken=1 and Br_offset=16'h0003 in the ID cycle; next cycle id_valid=0 (FLUSH); taken_cnt=1, br_cnt=1.
- BNE with rs_data=rt_data=32'hA -> Br_taken=0, no flush, id_valid stays 1, br_cnt=1, taken_cnt=0.
- BEQ in ID with hazard_stall=1 for 2 cycles -> if_en=0 and id_valid=0 for 2 cycles, id_instr held; then resolves taken on cycle 3.
- hazard_stall held 16 cycles -> stall_err=1 after cycle 15 and stays 1 after release; clears only on rst=0.
- rst asserted during FLUSH -> immediately id_valid=0, Br_taken=0, if_en=1, counters 0, state RUN.
- BR_DELAY_SLOT_EN build: taken BEQ -> the next-cycle instruction appears with id_valid=1 (no squash).
